// File: rtl/impulse_capture_ctrl.sv
// Impulse stimulus and capture controller: fires one symbol-aligned impulse, records a
// window of N_CH response channels into on-chip memory, then streams it out valid/ready.
module impulse_capture_ctrl #(
  parameter int DATA_W     = 18,
  parameter int N_CH       = 2,
  parameter int DEPTH      = 64,
  parameter int PRE_DELAY  = 30,
  parameter int CAP_OFFSET = 4,
  parameter int AMPLITUDE  = 32768
) (
  input  logic                                          sys_clk,
  input  logic                                          reset,
  input  logic                                          sam_clk_en,
  input  logic                                          sym_clk_en,
  input  logic                                          start,
  input  logic                                          repeat_en,
  input  logic [N_CH*DATA_W-1:0]                        resp,
  output logic [DATA_W-1:0]                             stimulus,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_W-1:0]                             out_data,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    out_ch,
  output logic [$clog2(DEPTH)-1:0]                      out_idx,
  output logic                                          out_last,
  output logic [1:0]                                    dbg_state
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (PRE_DELAY > CAP_OFFSET + DEPTH) ? PRE_DELAY : CAP_OFFSET + DEPTH;
  // One spare bit so that (cnt - constant) carries its sign in the MSB.
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

  localparam logic [CNT_W-1:0]  PRE_C    = CNT_W'(PRE_DELAY);
  localparam logic [CNT_W-1:0]  OFF_C    = CNT_W'(CAP_OFFSET);
  localparam logic [CNT_W-1:0]  LAST_K   = CNT_W'(CAP_OFFSET + DEPTH - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [AW-1:0]     IDX_LAST = AW'(DEPTH - 1);
  localparam logic [DATA_W-1:0] AMP      = DATA_W'(AMPLITUDE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   stimulus_q, stimulus_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [AW-1:0]       out_idx_q, out_idx_d;
  logic                out_last_q, out_last_d;
  logic [AW-1:0]       rd_idx_q, rd_idx_d;
  logic [CH_W-1:0]     rd_ch_q, rd_ch_d;
  logic                rd_ok_q, rd_ok_d;
  logic                exhausted_q, exhausted_d;

  logic [N_CH*DATA_W-1:0] mem [DEPTH];
  logic [N_CH*DATA_W-1:0] rd_word_q;

  logic [CNT_W-1:0] pre_diff;
  logic [CNT_W-1:0] wr_off;
  logic             pre_met;
  logic             in_window;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic             idx_step;
  logic             handshake;

  assign pre_diff  = cnt_q - PRE_C;
  assign pre_met   = ~pre_diff[CNT_W-1];
  assign wr_off    = cnt_q - OFF_C;
  assign in_window = ~wr_off[CNT_W-1];
  assign mem_addr  = wr_off[AW-1:0];
  assign handshake = out_valid_q && out_ready;

  // Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // once out_valid is raised, all out_* hold until that transfer happens.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stimulus_d  = stimulus_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    rd_idx_d    = rd_idx_q;
    rd_ch_d     = rd_ch_q;
    exhausted_d = exhausted_q;
    mem_we      = 1'b0;
    idx_step    = 1'b0;

    case (state_q)
      S_IDLE: begin
        stimulus_d = '0;
        if (start) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (sam_clk_en) begin
          if (pre_met && sym_clk_en) begin
            stimulus_d = AMP;
            cnt_d      = '0;
            state_d    = S_RUN;
          end else if (!pre_met) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        // cnt_q is k: each strobe here ends sample k and captures resp as seen during it.
        if (sam_clk_en) begin
          stimulus_d = '0;
          cnt_d      = cnt_q + 1'b1;
          mem_we     = in_window;
          if (cnt_q == LAST_K) begin
            state_d     = S_DRAIN;
            rd_idx_d    = '0;
            rd_ch_d     = '0;
            exhausted_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        stimulus_d = '0;
        if (handshake && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = repeat_en ? S_WAIT : S_IDLE;
        end else if (rd_ok_q && !exhausted_q && (!out_valid_q || out_ready)) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_word_q[rd_ch_q*DATA_W +: DATA_W];
          out_ch_d    = rd_ch_q;
          out_idx_d   = rd_idx_q;
          out_last_d  = (rd_idx_q == IDX_LAST) && (rd_ch_q == CH_LAST);
          if (rd_ch_q == CH_LAST) begin
            rd_ch_d = '0;
            if (rd_idx_q == IDX_LAST) begin
              exhausted_d = 1'b1;
            end else begin
              rd_idx_d = rd_idx_q + 1'b1;
              idx_step = 1'b1;
            end
          end else begin
            rd_ch_d = rd_ch_q + 1'b1;
          end
        end else if (handshake) begin
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // rd_word_q lags rd_idx_q by one clock, so it is stale right after an index step.
    rd_ok_d = (state_q == S_DRAIN) && !idx_step;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stimulus_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      rd_idx_q    <= '0;
      rd_ch_q     <= '0;
      rd_ok_q     <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stimulus_q  <= stimulus_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      rd_idx_q    <= rd_idx_d;
      rd_ch_q     <= rd_ch_d;
      rd_ok_q     <= rd_ok_d;
      exhausted_q <= exhausted_d;
    end
  end

  // Capture memory: one word holds every channel of one sample index.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[mem_addr] <= resp;
    end
    rd_word_q <= mem[rd_idx_q];
  end

  assign stimulus  = stimulus_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_impulse_capture_ctrl.sv
// Directed bench for impulse_capture_ctrl: a default instance and a CAP_OFFSET=0 instance
// with bench-side response models and hand-computed expected beat streams.
module tb_impulse_capture_ctrl;

  localparam int DATA_W = 18;
  localparam int DEPTH  = 64;
  localparam int BW     = 1 + 6 + 1 + DATA_W;

  // clock / reset / strobes
  logic       sys_clk = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] div_q   = 4'd0;
  logic       sam_clk_en;
  logic       sym_clk_en;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) div_q <= div_q + 4'd1;
  assign sam_clk_en = (div_q[1:0] == 2'b11);
  assign sym_clk_en = (div_q == 4'hF);

  // instance a: default parameters
  logic                start_a, repeat_a, ordy_a;
  logic [2*DATA_W-1:0] resp_a;
  logic [DATA_W-1:0]   stim_a, od_a;
  logic                busy_a, done_a, ov_a, olast_a;
  logic [0:0]          och_a;
  logic [5:0]          oidx_a;
  logic [1:0]          dbg_a;

  // instance b: capture offset zero
  logic                start_b, repeat_b, ordy_b;
  logic [2*DATA_W-1:0] resp_b;
  logic [DATA_W-1:0]   stim_b, od_b;
  logic                busy_b, done_b, ov_b, olast_b;
  logic [0:0]          och_b;
  logic [5:0]          oidx_b;
  logic [1:0]          dbg_b;

  impulse_capture_ctrl dut_a (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .start(start_a), .repeat_en(repeat_a), .resp(resp_a), .stimulus(stim_a),
    .busy(busy_a), .done(done_a), .out_valid(ov_a), .out_ready(ordy_a),
    .out_data(od_a), .out_ch(och_a), .out_idx(oidx_a), .out_last(olast_a),
    .dbg_state(dbg_a)
  );

  impulse_capture_ctrl #(.CAP_OFFSET(0)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .start(start_b), .repeat_en(repeat_b), .resp(resp_b), .stimulus(stim_b),
    .busy(busy_b), .done(done_b), .out_valid(ov_b), .out_ready(ordy_b),
    .out_data(od_b), .out_ch(och_b), .out_idx(oidx_b), .out_last(olast_b),
    .dbg_state(dbg_b)
  );

  // response models: sample-rate delay lines on the stimulus
  logic [DATA_W-1:0] d1_a = '0;
  logic [DATA_W-1:0] e1_b = '0;
  logic [DATA_W-1:0] e2_b = '0;
  always @(posedge sys_clk) begin
    if (sam_clk_en) begin
      d1_a <= stim_a;
      e1_b <= stim_b;
      e2_b <= e1_b;
    end
  end
  assign resp_a = {{DATA_W{1'b0}}, d1_a};
  assign resp_b = {-stim_b, e2_b};

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] got_a[$];
  logic [BW-1:0] got_b[$];
  int  done_cnt_a = 0, imp_cnt_a = 0, imp_off_sym = 0, busy_drop = 0;
  int  run_len_a = 0, last_len_a = 0, hold_viol = 0;
  bit  watch_busy = 0, throttle_b = 0, sym_prev = 0, hold_b = 0;
  logic [DATA_W-1:0] prev_stim_a = '0;
  logic [BW:0]       hold_snap_b = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (ov_a && ordy_a) got_a.push_back({olast_a, oidx_a, och_a, od_a});
    if (ov_b && ordy_b) got_b.push_back({olast_b, oidx_b, och_b, od_b});
    if (hold_b && ({ov_b, olast_b, oidx_b, och_b, od_b} != hold_snap_b)) hold_viol++;
    hold_b      = ov_b && !ordy_b;
    hold_snap_b = {ov_b, olast_b, oidx_b, och_b, od_b};
    if (done_a) done_cnt_a++;
    if (stim_a != '0 && prev_stim_a == '0) begin
      imp_cnt_a++;
      if (!sym_prev) imp_off_sym++;
    end
    if (stim_a != '0) run_len_a++;
    else if (prev_stim_a != '0) begin
      last_len_a = run_len_a;
      run_len_a  = 0;
    end
    if (watch_busy && !busy_a && !done_a) busy_drop++;
    prev_stim_a = stim_a;
    sym_prev    = sym_clk_en;
  end

  always @(posedge sys_clk) begin
    #1;
    if (throttle_b) ordy_b = 1'($urandom_range(0, 1));
  end

  // driver tasks
  task automatic pulse_start(input bit which, output int lat);
    int guard = 0;
    @(negedge sys_clk);
    while (!sym_clk_en && guard < 40) begin
      @(negedge sys_clk);
      guard++;
    end
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check_eq("busy_rise", which ? busy_b : busy_a, 1);
    lat = 1;
    while ((which ? stim_b : stim_a) == '0 && lat < 400) begin
      @(negedge sys_clk);
      lat++;
    end
  endtask

  task automatic wait_done(input bit which, input string tag);
    int guard = 0;
    @(negedge sys_clk);
    while (!(which ? done_b : done_a) && guard < 3000) begin
      @(negedge sys_clk);
      guard++;
    end
    check_eq(tag, which ? done_b : done_a, 1);
    check_eq({tag, "_valid_low"}, which ? ov_b : ov_a, 0);
  endtask

  task automatic compare_beats(input bit which, input bit pattern, input int runs, input string tag);
    logic [BW-1:0]     exp_q[$];
    logic [BW-1:0]     got[$];
    logic [DATA_W-1:0] dv;
    for (int r = 0; r < runs; r++)
      for (int i = 0; i < DEPTH; i++)
        for (int c = 0; c < 2; c++) begin
          dv = '0;
          if (pattern && i == 0 && c == 1) dv = 18'h38000;
          if (pattern && i == 2 && c == 0) dv = 18'h08000;
          exp_q.push_back({(i == DEPTH - 1 && c == 1), 6'(i), 1'(c), dv});
        end
    if (which) got = got_b; else got = got_a;
    check_eq({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
  endtask

  initial begin
    int lat;
    start_a = 0; start_b = 0; repeat_a = 0; repeat_b = 0; ordy_a = 1; ordy_b = 1;
    #2 reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_stim", stim_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_valid", ov_a, 0);
    check_eq("rst_data", od_a, 0);
    check_eq("rst_ch", och_a, 0);
    check_eq("rst_idx", oidx_a, 0);
    check_eq("rst_last", olast_a, 0);
    check_eq("rst_state", dbg_a, 0);
    reset = 1'b0;

    // defaults: delayed impulse lands before the capture window
    got_a.delete(); imp_off_sym = 0;
    pulse_start(0, lat);
    check_eq("t1_latency", lat, 129);
    wait_done(0, "t1_done");
    check_eq("t1_busy_end", busy_a, 0);
    check_eq("t1_pulse_len", last_len_a, 4);
    check_eq("t1_on_sym", imp_off_sym, 0);
    compare_beats(0, 0, 1, "t1");

    // capture offset zero, full-rate drain
    got_b.delete();
    pulse_start(1, lat);
    check_eq("t2_latency", lat, 129);
    wait_done(1, "t2_done");
    compare_beats(1, 1, 1, "t2");

    // same run with random backpressure
    got_b.delete(); hold_viol = 0; throttle_b = 1;
    pulse_start(1, lat);
    wait_done(1, "t3_done");
    throttle_b = 0;
    ordy_b = 1'b1;
    compare_beats(1, 1, 1, "t3");
    check_eq("t3_hold_stable", hold_viol, 0);

    // three back-to-back runs via repeat_en
    got_a.delete(); done_cnt_a = 0; imp_cnt_a = 0; imp_off_sym = 0; busy_drop = 0;
    repeat_a = 1'b1;
    pulse_start(0, lat);
    watch_busy = 1;
    wait_done(0, "t4_done1");
    wait_done(0, "t4_done2");
    repeat_a = 1'b0;
    wait_done(0, "t4_done3");
    watch_busy = 0;
    @(negedge sys_clk);
    check_eq("t4_done_cnt", done_cnt_a, 3);
    check_eq("t4_impulses", imp_cnt_a, 3);
    check_eq("t4_on_sym", imp_off_sym, 0);
    check_eq("t4_busy_drop", busy_drop, 0);
    check_eq("t4_idle", busy_a, 0);
    compare_beats(0, 0, 3, "t4");

    // start pulses during RUN and DRAIN are ignored
    got_a.delete(); imp_cnt_a = 0;
    pulse_start(0, lat);
    start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    for (int g = 0; g < 2000 && !ov_a; g++) @(negedge sys_clk);
    start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    wait_done(0, "t5_done");
    repeat (200) @(negedge sys_clk);
    check_eq("t5_idle", busy_a, 0);
    check_eq("t5_impulses", imp_cnt_a, 1);
    compare_beats(0, 0, 1, "t5");

    // reset in the middle of RUN, then a clean run
    pulse_start(0, lat);
    repeat (20) @(negedge sys_clk);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_stim", stim_a, 0);
    check_eq("t6_rst_busy", busy_a, 0);
    check_eq("t6_rst_valid", ov_a, 0);
    check_eq("t6_rst_done", done_a, 0);
    check_eq("t6_rst_state", dbg_a, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    got_a.delete();
    pulse_start(0, lat);
    check_eq("t6_latency", lat, 129);
    wait_done(0, "t6_done");
    compare_beats(0, 0, 1, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
